// File: rtl/alu_op_sequencer.sv
// Per-nibble ALU sequencer: captures operands, commits result/flags, then
// soft-ramps the PWM setpoint toward the committed result.
module alu_op_sequencer #(
  parameter int RAMP_DIV = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] spi_data,
  input  logic       spi_valid,
  input  logic [1:0] sensor_code,
  input  logic [1:0] op_code,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [1:0] alu_sel,
  input  logic [7:0] alu_result,
  input  logic [3:0] alu_flags,
  output logic [3:0] result_q,
  output logic [3:0] flags_q,
  output logic [3:0] pwm_level,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, EXEC, COMMIT, RAMP} state_t;

  localparam logic [15:0] DIV_M1 = 16'(RAMP_DIV - 1);

  state_t      state, state_d;
  logic        pending;
  logic [3:0]  pend_data;
  logic [15:0] ramp_cnt;

  logic        capture, set_pend, clr_pend, commit, cnt_run;
  logic [3:0]  cap_data;

  // Upper result bits carry nothing the flags do not already encode.
  logic unused_hi;
  assign unused_hi = ^alu_result[7:4];

  assign busy = (state != IDLE);

  always_comb begin
    state_d  = state;
    capture  = 1'b0;
    cap_data = spi_data;
    set_pend = 1'b0;
    clr_pend = 1'b0;
    commit   = 1'b0;
    cnt_run  = 1'b0;
    case (state)
      IDLE, RAMP: begin
        // A fresh strobe wins over (and discards) any buffered nibble; in RAMP
        // either one aborts the ramp with pwm_level left where it is.
        if (spi_valid) begin
          capture  = 1'b1;
          clr_pend = 1'b1;
          state_d  = EXEC;
        end else if (pending) begin
          capture  = 1'b1;
          cap_data = pend_data;
          clr_pend = 1'b1;
          state_d  = EXEC;
        end else if (state == RAMP) begin
          if (pwm_level == result_q) state_d = IDLE;
          else                       cnt_run = 1'b1;
        end
      end
      EXEC: begin
        set_pend = spi_valid;
        state_d  = COMMIT;
      end
      COMMIT: begin
        set_pend = spi_valid;
        commit   = 1'b1;
        state_d  = RAMP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      result_q  <= '0;
      flags_q   <= '0;
      pwm_level <= '0;
      done      <= 1'b0;
      pending   <= 1'b0;
      pend_data <= '0;
      ramp_cnt  <= '0;
    end else begin
      state <= state_d;
      done  <= commit;
      if (capture) begin
        alu_a   <= cap_data;
        alu_b   <= {2'b00, sensor_code};
        alu_sel <= op_code;
      end
      if (set_pend) begin
        pending   <= 1'b1;
        pend_data <= spi_data;
      end else if (clr_pend) begin
        pending <= 1'b0;
      end
      if (commit) begin
        result_q <= alu_result[3:0];
        flags_q  <= alu_flags;
        ramp_cnt <= '0;
      end else if (cnt_run) begin
        if (ramp_cnt == DIV_M1) begin
          ramp_cnt  <= '0;
          pwm_level <= (pwm_level < result_q) ? pwm_level + 4'd1 : pwm_level - 4'd1;
        end else begin
          ramp_cnt <= ramp_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: vector table plus latency, pending,
// abort, flag-hold and async-reset sequences against two RAMP_DIV builds.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] spi_data = '0;
  logic       spi_valid = 1'b0;
  logic [1:0] sensor_code = '0;
  logic [1:0] op_code = '0;
  logic       sel = 1'b0;

  logic [3:0] a4, b4, r4, f4, p4, a8, b8, r8, f8, p8, fl4, fl8;
  logic [1:0] s4, s8;
  logic [7:0] res4, res8;
  logic       busy4, done4, busy8, done8;

  int tests = 0, failed = 0;
  int dcnt4 = 0, dcnt8 = 0;

  always #5 clk = ~clk;

  // ALU stub: 00 add, 01 sub, 10 and, 11 or; returns {S,V,C,Z, result[7:0]}
  function automatic logic [11:0] alu_stub(input logic [3:0] a, input logic [3:0] b,
                                           input logic [1:0] s);
    logic [7:0] r;
    case (s)
      2'd0:    r = {4'b0, a} + {4'b0, b};
      2'd1:    r = {4'b0, a} - {4'b0, b};
      2'd2:    r = {4'b0, a & b};
      default: r = {4'b0, a | b};
    endcase
    return {r[3], 1'b0, r[4], (r[3:0] == 4'd0), r};
  endfunction

  assign {fl4, res4} = alu_stub(a4, b4, s4);
  assign {fl8, res8} = alu_stub(a8, b8, s8);

  alu_op_sequencer #(.RAMP_DIV(4)) u_dut4 (
    .clk(clk), .rst(rst), .spi_data(spi_data), .spi_valid(spi_valid & ~sel),
    .sensor_code(sensor_code), .op_code(op_code),
    .alu_a(a4), .alu_b(b4), .alu_sel(s4), .alu_result(res4), .alu_flags(fl4),
    .result_q(r4), .flags_q(f4), .pwm_level(p4), .busy(busy4), .done(done4));

  alu_op_sequencer #(.RAMP_DIV(8)) u_dut8 (
    .clk(clk), .rst(rst), .spi_data(spi_data), .spi_valid(spi_valid & sel),
    .sensor_code(sensor_code), .op_code(op_code),
    .alu_a(a8), .alu_b(b8), .alu_sel(s8), .alu_result(res8), .alu_flags(fl8),
    .result_q(r8), .flags_q(f8), .pwm_level(p8), .busy(busy8), .done(done8));

  always @(negedge clk) begin
    if (done4) dcnt4++;
    if (done8) dcnt8++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive a one-cycle strobe; returns 1ns after the sampling edge.
  task automatic strobe(input logic s, input logic [3:0] d, input logic [1:0] sc,
                        input logic [1:0] op);
    sel = s; spi_data = d; sensor_code = sc; op_code = op; spi_valid = 1'b1;
    tick(1);
    spi_valid = 1'b0;
  endtask

  task automatic wait_idle(input logic s, input int lim, input string nm);
    int n = 0;
    while ((s ? busy8 : busy4) && n < lim) begin
      tick(1);
      n++;
    end
    chk({nm, "_idle_timeout"}, {31'd0, (s ? busy8 : busy4)}, 0);
  endtask

  typedef struct {
    logic [3:0] data;
    logic [1:0] sens;
    logic [1:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] sl;
    logic [3:0] res;
    logic [3:0] flg;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int d0, n;
    //           data  sens  op    a     b     sel   res   {S,V,C,Z}
    vecs[0] = '{4'h1, 2'd0, 2'd0, 4'h1, 4'h0, 2'd0, 4'h1, 4'b0000}; // ramp 7 -> 1
    vecs[1] = '{4'hF, 2'd3, 2'd0, 4'hF, 4'h3, 2'd0, 4'h2, 4'b0010}; // 0x12: carry
    vecs[2] = '{4'hC, 2'd1, 2'd1, 4'hC, 4'h1, 2'd1, 4'hB, 4'b1000}; // sub, sign
    vecs[3] = '{4'h2, 2'd3, 2'd1, 4'h2, 4'h3, 2'd1, 4'hF, 4'b1010}; // borrow
    vecs[4] = '{4'hA, 2'd2, 2'd2, 4'hA, 4'h2, 2'd2, 4'h2, 4'b0000}; // and
    vecs[5] = '{4'h4, 2'd3, 2'd3, 4'h4, 4'h3, 2'd3, 4'h7, 4'b0000}; // or
    vecs[6] = '{4'h0, 2'd0, 2'd0, 4'h0, 4'h0, 2'd0, 4'h0, 4'b0001}; // zero flag

    // Reset and idle
    tick(3);
    chk("rst_pwm", p4, 0);
    chk("rst_busy", busy4, 0);
    #2 rst = 1'b0;
    tick(10);
    chk("idle_outs", {a4, b4, s4, r4, f4, p4}, 0);
    chk("idle_busy_done", {busy4, done4}, 0);
    chk("idle_dut8", {a8, b8, s8, r8, f8, p8, busy8, done8}, 0);

    // Latency and ramp-up 0 -> 7 with RAMP_DIV=4
    d0 = dcnt4;
    strobe(0, 4'h5, 2'b10, 2'd0);                     // edge 0
    chk("lat_a", a4, 5);
    chk("lat_b", b4, 2);
    chk("lat_busy", busy4, 1);
    chk("lat_e0_res", r4, 0);
    tick(1);                                          // edge 1
    chk("lat_e1_res", r4, 0);
    tick(1);                                          // edge 2
    chk("lat_e2_res", r4, 7);
    chk("lat_e2_flags", f4, 0);
    chk("lat_e2_done", done4, 1);
    tick(1);                                          // edge 3
    chk("lat_e3_done", done4, 0);
    tick(2);                                          // edge 5
    chk("ramp_e5_pwm", p4, 0);
    tick(1);                                          // edge 6
    chk("ramp_e6_pwm", p4, 1);
    wait_idle(0, 100, "ramp_up");
    chk("ramp_up_pwm", p4, 7);
    chk("ramp_up_dones", dcnt4 - d0, 1);

    // Vector table
    for (int i = 0; i < 7; i++) begin
      d0 = dcnt4;
      strobe(0, vecs[i].data, vecs[i].sens, vecs[i].op);
      wait_idle(0, 300, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_a", i), a4, vecs[i].a);
      chk($sformatf("vec%0d_b", i), b4, vecs[i].b);
      chk($sformatf("vec%0d_sel", i), s4, vecs[i].sl);
      chk($sformatf("vec%0d_res", i), r4, vecs[i].res);
      chk($sformatf("vec%0d_flags", i), f4, vecs[i].flg);
      chk($sformatf("vec%0d_pwm", i), p4, vecs[i].res);
      chk($sformatf("vec%0d_dones", i), dcnt4 - d0, 1);
    end

    // Strobe during EXEC goes to pending; flags held until the next commit
    d0 = dcnt4;
    strobe(0, 4'h3, 2'd0, 2'd0);                      // edge 0
    spi_data = 4'h9; spi_valid = 1'b1;
    tick(1);                                          // edge 1 (EXEC)
    spi_valid = 1'b0;
    chk("pend_e1_flags_hold", f4, 4'b0001);
    chk("pend_e1_res_hold", r4, 0);
    tick(1);                                          // edge 2
    chk("pend_first_res", r4, 3);
    chk("pend_first_flags", f4, 0);
    tick(1);                                          // edge 3: pending recaptured
    chk("pend_recap_a", a4, 9);
    chk("pend_no_step", p4, 0);
    tick(2);                                          // edge 5
    chk("pend_second_res", r4, 9);
    wait_idle(0, 100, "pend");
    chk("pend_pwm", p4, 9);
    chk("pend_dones", dcnt4 - d0, 2);

    // Abort mid-ramp on the RAMP_DIV=8 instance
    d0 = dcnt8;
    strobe(1, 4'hF, 2'd0, 2'd0);
    n = 0;
    while (p8 != 4'd3 && n < 200) begin
      tick(1);
      n++;
    end
    chk("abort_reach3", p8, 3);
    strobe(1, 4'h2, 2'd0, 2'd0);                      // captured in RAMP
    chk("abort_hold_pwm", p8, 3);
    chk("abort_a", a8, 2);
    tick(2);                                          // commit edge
    chk("abort_res", r8, 2);
    chk("abort_hold_commit", p8, 3);
    tick(7);
    chk("abort_pre_step", p8, 3);
    tick(1);
    chk("abort_step", p8, 2);
    wait_idle(1, 50, "abort");
    chk("abort_final_pwm", p8, 2);
    chk("abort_dones", dcnt8 - d0, 2);
    chk("abort_dut4_quiet", {busy4, p4}, {1'b0, 4'd9});

    // Asynchronous reset mid-RAMP
    strobe(0, 4'hF, 2'd0, 2'd0);
    n = 0;
    while (p4 < 4'd11 && n < 200) begin
      tick(1);
      n++;
    end
    chk("arst_reach11", p4, 11);
    chk("arst_busy_pre", busy4, 1);
    d0 = dcnt4;
    #2 rst = 1'b1;
    #1;
    chk("arst_pwm", p4, 0);
    chk("arst_outs", {a4, b4, s4, r4, f4}, 0);
    chk("arst_busy_done", {busy4, done4}, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    tick(6);
    chk("arst_after", {busy4, p4, r4}, 0);
    chk("arst_no_done", dcnt4 - d0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
